// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: front-end sequencer for the signed 16-bit ALU.
// Takes one command per valid/ready handshake and drives registered operands,
// a one-hot unit enable and a 2-bit function code to the units. It then waits
// out the units' one-cycle registered latency, captures the selected result
// and flag, and holds that result until downstream accepts it.
module alu_issue_ctrl #(
  parameter int in_data_width  = 16,
  parameter int out_data_width = 16,
  parameter int cnt_width      = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  // command side
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic signed [in_data_width-1:0]  A,
  input  logic signed [in_data_width-1:0]  B,
  input  logic        [3:0]                alu_fun,
  // unit drive
  output logic signed [in_data_width-1:0]  op_A,
  output logic signed [in_data_width-1:0]  op_B,
  output logic        [1:0]                alu_fn,
  output logic                             arith_enable,
  output logic                             logic_enable,
  output logic                             cmp_enable,
  output logic                             shift_enable,
  // unit results, registered by the units at the end of ISSUE
  input  logic signed [out_data_width-1:0] arith_out,
  input  logic signed [out_data_width-1:0] logic_out,
  input  logic signed [out_data_width-1:0] cmp_out,
  input  logic signed [out_data_width-1:0] shift_out,
  input  logic                             arith_flag,
  input  logic                             logic_flag,
  input  logic                             cmp_flag,
  input  logic                             shift_flag,
  // result side
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic signed [out_data_width-1:0] result,
  output logic                             res_err,
  output logic        [cnt_width-1:0]      op_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t                           state_q;
  logic signed [in_data_width-1:0]  opA_q;
  logic signed [in_data_width-1:0]  opB_q;
  logic        [1:0]                fn_q;
  logic        [1:0]                unitSel_q;
  logic        [3:0]                enable_q;
  logic signed [out_data_width-1:0] result_q;
  logic                             resValid_q;
  logic                             resErr_q;
  logic        [cnt_width-1:0]      opCount_q;

  logic        [3:0]                enable_d;
  logic signed [out_data_width-1:0] selOut_d;
  logic                             selFlag_d;
  logic        [cnt_width-1:0]      opCount_d;

  // Decode the incoming unit select into a one-hot enable, bit order {shift, cmp, logic, arith}
  always_comb begin
    enable_d = 4'b0000;
    unique case (alu_fun[3:2])
      2'b00:   enable_d = 4'b0001;
      2'b01:   enable_d = 4'b0010;
      2'b10:   enable_d = 4'b0100;
      2'b11:   enable_d = 4'b1000;
      default: enable_d = 4'b0000;
    endcase
  end

  // Pick the result and flag of the unit chosen by the latched command, plus the wrapping counter increment
  always_comb begin
    selOut_d  = arith_out;
    selFlag_d = arith_flag;
    unique case (unitSel_q)
      2'b00: begin
        selOut_d  = arith_out;
        selFlag_d = arith_flag;
      end
      2'b01: begin
        selOut_d  = logic_out;
        selFlag_d = logic_flag;
      end
      2'b10: begin
        selOut_d  = cmp_out;
        selFlag_d = cmp_flag;
      end
      2'b11: begin
        selOut_d  = shift_out;
        selFlag_d = shift_flag;
      end
      default: begin
        selOut_d  = arith_out;
        selFlag_d = arith_flag;
      end
    endcase
    opCount_d = opCount_q + cnt_width'(1);
  end

  // Sequencer FSM with registered outputs; reset overrides everything, including a mid-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opA_q      <= '0;
      opB_q      <= '0;
      fn_q       <= '0;
      unitSel_q  <= '0;
      enable_q   <= '0;
      result_q   <= '0;
      resValid_q <= 1'b0;
      resErr_q   <= 1'b0;
      opCount_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            opA_q     <= A;
            opB_q     <= B;
            fn_q      <= alu_fun[1:0];
            unitSel_q <= alu_fun[3:2];
            enable_q  <= enable_d;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          enable_q <= '0;
          state_q  <= CAPTURE;
        end
        CAPTURE: begin
          result_q   <= selOut_d;
          resErr_q   <= ~selFlag_d;
          resValid_q <= 1'b1;
          opCount_q  <= opCount_d;
          state_q    <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            resValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          enable_q <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Ready is a state decode, masked while reset is applied so no handshake is seen during reset
  assign cmd_ready = (state_q == IDLE) && !rst;

  assign op_A         = opA_q;
  assign op_B         = opB_q;
  assign alu_fn       = fn_q;
  assign arith_enable = enable_q[0];
  assign logic_enable = enable_q[1];
  assign cmp_enable   = enable_q[2];
  assign shift_enable = enable_q[3];
  assign res_valid    = resValid_q;
  assign result       = result_q;
  assign res_err      = resErr_q;
  assign op_count     = opCount_q;

  // Enables must be one-hot-or-zero and may only be high in ISSUE
  enOneHot : assert property (@(posedge clk) disable iff (rst) $onehot0(enable_q));
  enIssueOnly : assert property (@(posedge clk) disable iff (rst) (|enable_q) |-> (state_q == ISSUE));

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed, table-driven bench for alu_issue_ctrl.
// Small registered unit models sit behind the DUT; expected values are hand-computed.
module tb_alu_issue_ctrl;

  localparam int InW  = 16;
  localparam int OutW = 16;
  localparam int CntW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            cmdValid;
  logic            cmdReady;
  logic [InW-1:0]  aIn;
  logic [InW-1:0]  bIn;
  logic [3:0]      aluFun;
  logic [InW-1:0]  opA;
  logic [InW-1:0]  opB;
  logic [1:0]      aluFn;
  logic            arithEnable;
  logic            logicEnable;
  logic            cmpEnable;
  logic            shiftEnable;
  logic [OutW-1:0] arithOut = '0;
  logic [OutW-1:0] logicOut = '0;
  logic [OutW-1:0] cmpOut   = '0;
  logic [OutW-1:0] shiftOut = '0;
  logic            arithFlag = 1'b0;
  logic            logicFlag = 1'b0;
  logic            cmpFlag   = 1'b0;
  logic            shiftFlag = 1'b0;
  logic            resValid;
  logic            resReady;
  logic [OutW-1:0] result;
  logic            resErr;
  logic [CntW-1:0] opCount;

  logic [3:0]      enables;
  logic            flagCtl = 1'b1;
  logic [CntW-1:0] expCount = '0;
  int              checkCount = 0;
  int              passCount  = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
    logic        flag;
    logic [3:0]  expEn;
    logic [15:0] expResult;
    logic        expErr;
  } vec_t;

  vec_t vecs[10];

  assign enables = {shiftEnable, cmpEnable, logicEnable, arithEnable};

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .in_data_width (InW),
    .out_data_width(OutW),
    .cnt_width     (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmdValid),
    .cmd_ready   (cmdReady),
    .A           (aIn),
    .B           (bIn),
    .alu_fun     (aluFun),
    .op_A        (opA),
    .op_B        (opB),
    .alu_fn      (aluFn),
    .arith_enable(arithEnable),
    .logic_enable(logicEnable),
    .cmp_enable  (cmpEnable),
    .shift_enable(shiftEnable),
    .arith_out   (arithOut),
    .logic_out   (logicOut),
    .cmp_out     (cmpOut),
    .shift_out   (shiftOut),
    .arith_flag  (arithFlag),
    .logic_flag  (logicFlag),
    .cmp_flag    (cmpFlag),
    .shift_flag  (shiftFlag),
    .res_valid   (resValid),
    .res_ready   (resReady),
    .result      (result),
    .res_err     (resErr),
    .op_count    (opCount)
  );

  // Registered unit models: each updates its result and flag only in the cycle its enable is high
  always @(posedge clk) begin
    if (arithEnable) begin
      case (aluFn)
        2'b00:   arithOut <= opA + opB;
        2'b01:   arithOut <= opA - opB;
        2'b10:   arithOut <= opB - opA;
        default: arithOut <= opA;
      endcase
      arithFlag <= flagCtl;
    end
    if (logicEnable) begin
      case (aluFn)
        2'b00:   logicOut <= opA & opB;
        2'b01:   logicOut <= opA | opB;
        2'b10:   logicOut <= opA ^ opB;
        default: logicOut <= ~(opA | opB);
      endcase
      logicFlag <= flagCtl;
    end
    if (cmpEnable) begin
      case (aluFn)
        2'b00:   cmpOut <= {15'd0, opA == opB};
        2'b01:   cmpOut <= {15'd0, $signed(opA) < $signed(opB)};
        2'b10:   cmpOut <= {15'd0, $signed(opA) > $signed(opB)};
        default: cmpOut <= {15'd0, opA != opB};
      endcase
      cmpFlag <= flagCtl;
    end
    if (shiftEnable) begin
      case (aluFn)
        2'b00:   shiftOut <= opA << opB[3:0];
        2'b01:   shiftOut <= opA >> opB[3:0];
        2'b10:   shiftOut <= $signed(opA) >>> opB[3:0];
        default: shiftOut <= opA;
      endcase
      shiftFlag <= flagCtl;
    end
  end

  // Compare one observed value against its expected value and keep the tallies
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Run one full operation with res_ready=1, starting and ending at a negedge in IDLE
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag      = $sformatf("v%0d", idx);
    aIn      = v.a;
    bIn      = v.b;
    aluFun   = v.fun;
    flagCtl  = v.flag;
    resReady = 1'b1;
    cmdValid = 1'b1;
    checkOutput({tag, ".idleReady"}, 32'(cmdReady), 32'd1);
    @(negedge clk);
    cmdValid = 1'b0;
    checkOutput({tag, ".issueEn"}, 32'(enables), 32'(v.expEn));
    checkOutput({tag, ".issueFn"}, 32'(aluFn), 32'(v.fun[1:0]));
    checkOutput({tag, ".opA"}, 32'(opA), 32'(v.a));
    checkOutput({tag, ".opB"}, 32'(opB), 32'(v.b));
    checkOutput({tag, ".issueReady"}, 32'(cmdReady), 32'd0);
    checkOutput({tag, ".issueValid"}, 32'(resValid), 32'd0);
    @(negedge clk);
    checkOutput({tag, ".captEn"}, 32'(enables), 32'd0);
    checkOutput({tag, ".captValid"}, 32'(resValid), 32'd0);
    checkOutput({tag, ".captReady"}, 32'(cmdReady), 32'd0);
    @(negedge clk);
    expCount = expCount + 1'b1;
    checkOutput({tag, ".resValid"}, 32'(resValid), 32'd1);
    checkOutput({tag, ".result"}, 32'(result), 32'(v.expResult));
    checkOutput({tag, ".resErr"}, 32'(resErr), 32'(v.expErr));
    checkOutput({tag, ".opCount"}, 32'(opCount), 32'(expCount));
    checkOutput({tag, ".holdEn"}, 32'(enables), 32'd0);
    @(negedge clk);
    checkOutput({tag, ".doneValid"}, 32'(resValid), 32'd0);
    checkOutput({tag, ".doneReady"}, 32'(cmdReady), 32'd1);
  endtask

  initial begin
    //          a         b         fun      flag  expEn    expResult  expErr
    vecs[0] = '{16'h00F0, 16'h0FF0, 4'b0100, 1'b1, 4'b0010, 16'h00F0, 1'b0}; // AND
    vecs[1] = '{16'h0000, 16'h0001, 4'b0111, 1'b1, 4'b0010, 16'hFFFE, 1'b0}; // NOR
    vecs[2] = '{16'h1234, 16'h0101, 4'b0000, 1'b1, 4'b0001, 16'h1335, 1'b0}; // add
    vecs[3] = '{16'h0005, 16'h0007, 4'b0001, 1'b1, 4'b0001, 16'hFFFE, 1'b0}; // sub
    vecs[4] = '{16'hFFFF, 16'h0001, 4'b1001, 1'b0, 4'b0100, 16'h0001, 1'b1}; // -1 < 1, flag low
    vecs[5] = '{16'h0005, 16'h0005, 4'b1000, 1'b1, 4'b0100, 16'h0001, 1'b0}; // eq, flag back high
    vecs[6] = '{16'h0003, 16'h0004, 4'b1100, 1'b1, 4'b1000, 16'h0030, 1'b0}; // shl
    vecs[7] = '{16'h8000, 16'h0004, 4'b1110, 1'b0, 4'b1000, 16'hF800, 1'b1}; // asr, flag low
    vecs[8] = '{16'hAAAA, 16'hFFFF, 4'b0110, 1'b1, 4'b0010, 16'h5555, 1'b0}; // XOR
    vecs[9] = '{16'h7FFF, 16'h8000, 4'b1010, 1'b1, 4'b0100, 16'h0001, 1'b0}; // max > min

    rst      = 1'b1;
    cmdValid = 1'b0;
    resReady = 1'b0;
    aIn      = '0;
    bIn      = '0;
    aluFun   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstReady", 32'(cmdReady), 32'd0);
    checkOutput("rstValid", 32'(resValid), 32'd0);
    checkOutput("rstResult", 32'(result), 32'd0);
    checkOutput("rstErr", 32'(resErr), 32'd0);
    checkOutput("rstCount", 32'(opCount), 32'd0);
    checkOutput("rstEn", 32'(enables), 32'd0);
    checkOutput("rstOpA", 32'(opA), 32'd0);
    checkOutput("rstFn", 32'(aluFn), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postRstReady", 32'(cmdReady), 32'd1);

    // Table vectors, issued back to back at the minimum 4-cycle spacing
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // Backpressure: NOR held for several cycles while a second command waits
    aIn = 16'h0000; bIn = 16'h0001; aluFun = 4'b0111; flagCtl = 1'b1;
    resReady = 1'b0; cmdValid = 1'b1;
    @(negedge clk);
    aIn = 16'h0002; bIn = 16'h0003; aluFun = 4'b0000;
    checkOutput("bpIssueEn", 32'(enables), 32'b0010);
    checkOutput("bpIssueReady", 32'(cmdReady), 32'd0);
    @(negedge clk);
    checkOutput("bpCaptReady", 32'(cmdReady), 32'd0);
    @(negedge clk);
    expCount = expCount + 1'b1;
    checkOutput("bpCount", 32'(opCount), 32'(expCount));
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("bpHoldValid%0d", i), 32'(resValid), 32'd1);
      checkOutput($sformatf("bpHoldResult%0d", i), 32'(result), 32'hFFFE);
      checkOutput($sformatf("bpHoldReady%0d", i), 32'(cmdReady), 32'd0);
      checkOutput($sformatf("bpHoldOpA%0d", i), 32'(opA), 32'h0000);
      @(negedge clk);
    end
    checkOutput("bpStillValid", 32'(resValid), 32'd1);
    resReady = 1'b1;
    @(negedge clk);
    checkOutput("bpRelValid", 32'(resValid), 32'd0);
    checkOutput("bpRelReady", 32'(cmdReady), 32'd1);
    checkOutput("bpRelOpA", 32'(opA), 32'h0000);
    @(negedge clk);
    cmdValid = 1'b0;
    checkOutput("bp2OpA", 32'(opA), 32'h0002);
    checkOutput("bp2OpB", 32'(opB), 32'h0003);
    checkOutput("bp2En", 32'(enables), 32'b0001);
    @(negedge clk);
    @(negedge clk);
    expCount = expCount + 1'b1;
    checkOutput("bp2Result", 32'(result), 32'h0005);
    checkOutput("bp2Valid", 32'(resValid), 32'd1);
    checkOutput("bp2Count", 32'(opCount), 32'(expCount));
    @(negedge clk);
    checkOutput("bp2Done", 32'(cmdReady), 32'd1);

    // Reset asserted while the controller is in CAPTURE
    aIn = 16'h0001; bIn = 16'h0002; aluFun = 4'b0101; cmdValid = 1'b1;
    @(negedge clk);
    cmdValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstValid", 32'(resValid), 32'd0);
    checkOutput("midRstResult", 32'(result), 32'd0);
    checkOutput("midRstCount", 32'(opCount), 32'd0);
    checkOutput("midRstReady", 32'(cmdReady), 32'd0);
    checkOutput("midRstOpA", 32'(opA), 32'd0);
    checkOutput("midRstEn", 32'(enables), 32'd0);
    rst = 1'b0;
    expCount = '0;
    @(negedge clk);
    checkOutput("midRstReadyAfter", 32'(cmdReady), 32'd1);
    checkOutput("midRstValidAfter", 32'(resValid), 32'd0);

    // Sixteen operations wrap the 4-bit counter back to zero
    for (int i = 0; i < 16; i++) applyStimulus(vecs[i % 10], 100 + i);
    checkOutput("wrapCount", 32'(opCount), 32'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Front-end sequencer for the signed 16-bit ALU; sits directly upstream of the arithmetic, logic, compare and shift units.
- Accepts one command (operands plus 4-bit function) per valid/ready handshake and decodes it to a one-hot unit enable plus a 2-bit `alu_fn`.
- Drives registered operands to the units, waits out their one-cycle registered latency, and captures the selected unit's result and flag.
- Presents the captured result downstream on a valid/ready handshake and counts completed operations.

Parameters:
- in_data_width, 16, operand width (signed)
- out_data_width, 16, unit result width and result port width
- cnt_width, 16, width of completed-operation counter

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- A  input  in_data_width  signed operand A
- B  input  in_data_width  signed operand B
- alu_fun  input  4  [3:2] unit select (00 arith, 01 logic, 10 cmp, 11 shift); [1:0] unit function
- op_A  output  in_data_width  registered operand A to all units
- op_B  output  in_data_width  registered operand B to all units
- alu_fn  output  2  function code to all units
- arith_enable, logic_enable, cmp_enable, shift_enable  output  1 each  one-hot unit enables
- arith_out, logic_out, cmp_out, shift_out  input  out_data_width each  registered unit results
- arith_flag, logic_flag, cmp_flag, shift_flag  input  1 each  registered unit flags
- res_valid  output  1  result held for downstream
- res_ready  input  1  downstream accepts result
- result  output  out_data_width  captured result
- res_err  output  1  selected unit flag was 0 at capture
- op_count  output  cnt_width  completed operations

Behaviour:
- Reset: synchronous; `rst`=1 at a rising edge forces the following, overriding any state including mid-operation:
  - state=IDLE
  - op_A, op_B, alu_fn, result = 0
  - all enables, res_valid, res_err = 0
  - op_count=0
  - cmd_ready=0 during the reset cycle, 1 in the first IDLE cycle after it.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
- IDLE:
  - cmd_ready=1; all enables 0.
  - On cmd_valid&cmd_ready: latch A→op_A, B→op_B, alu_fun→internal command register; go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - Exactly one enable=1, per command[3:2]; alu_fn=command[1:0].
  - Go to CAPTURE unconditionally.
- CAPTURE (exactly 1 cycle):
  - Enables 0. The selected unit's out/flag registered at the end of ISSUE are valid now.
  - result ← selected *_out; res_err ← ~selected *_flag; res_valid←1.
  - op_count increments, wrapping from all-ones to 0.
  - Go to HOLD.
- HOLD:
  - result, res_err, res_valid held stable while res_ready=0.
  - On res_ready=1: res_valid←0, go to IDLE.
- cmd_ready=0 in ISSUE, CAPTURE and HOLD; a cmd_valid asserted there is ignored and must be held by the source.
- Latency and throughput:
  - Command handshake edge to res_valid high = 3 edges.
  - Minimum 4 cycles per op when res_ready is tied 1.
  - A new command is accepted no earlier than the cycle after the result handshake.
- op_A, op_B and alu_fn hold their last values outside ISSUE. Only the enables gate unit activity.
- Enables are never asserted simultaneously, and never outside ISSUE.
- No arithmetic is performed here. Operands pass through unmodified at full signed width; result width = out_data_width.

Test Plan:
- Logic AND, res_ready=1: A=16'h00F0, B=16'h0FF0, alu_fun=4'b0100 → logic_enable high for exactly 1 cycle with alu_fn=00; result=16'h00F0, res_err=0, res_valid high 3 edges after handshake; op_count=1.
- Back-to-back with backpressure: logic NOR (alu_fun=4'b0111, A=16'h0000, B=16'h0001) with res_ready=0 for 5 cycles → result=16'hFFFE held stable; cmd_ready=0 throughout; a second command is accepted only in the cycle after res_ready=1.
- Unit select decode: issue alu_fun 0000, 0100, 1000, 1100 → enables respectively arith, logic, cmp, shift, each one-hot for 1 cycle; no enable ever high outside ISSUE.
- Error flag: bench unit model drives cmp_flag=0 at capture → res_err=1 and the result is still delivered; the next op with flag=1 → res_err=0.
- Reset mid-operation: assert rst during CAPTURE → next edge gives IDLE, res_valid=0, result=0, op_count=0; cmd_ready=1 the cycle after rst deasserts.
- Counter wrap with cnt_width=4: run 16 ops → op_count returns to 0 after the 16th capture.
